// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: field layout,
// fetch FSM encoding and the opcode values the control unit decodes.
package fetch_pkg;

  localparam int OPC_MSB   = 23;
  localparam int OPC_LSB   = 19;
  localparam int ALUOP_MSB = 18;
  localparam int ALUOP_LSB = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 12;
  localparam int RN_MSB    = 11;
  localparam int RN_LSB    = 8;
  localparam int RM_MSB    = 3;
  localparam int RM_LSB    = 0;
  localparam int IMM_MSB   = 11;
  localparam int IMM_LSB   = 0;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [4:0] OPC_R       = 5'b00000;
  localparam logic [4:0] OPC_LDR     = 5'b00001;
  localparam logic [4:0] OPC_STR     = 5'b00010;
  localparam logic [4:0] OPC_BEQ     = 5'b00011;
  localparam logic [4:0] OPC_BEQ_ALT = 5'b00101;
  localparam logic [4:0] OPC_ADDI    = 5'b00100;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of a 24-bit instruction word into its named
// fields; shared by the fetch unit and the debugger/trace path.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [23:0] instr,
  output logic [4:0]  opcode,
  output logic [2:0]  aluop,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [11:0] imm
);

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign aluop  = instr[ALUOP_MSB:ALUOP_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign rn     = instr[RN_MSB:RN_LSB];
  assign rm     = instr[RM_MSB:RM_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, fetches over req/ack, holds one instruction
// and offers its fields downstream over valid/ready, with branch redirects.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         opcode,
  output logic [2:0]         aluop,
  output logic [3:0]         rd,
  output logic [3:0]         rn,
  output logic [3:0]         rm,
  output logic [11:0]        imm,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;
  logic               squash_q, squash_d;
  logic               hold_valid_q, hold_valid_d;
  logic               ack_s;
  logic               out_valid_s;

  // A late ack with no request outstanding must not be taken as data.
  assign ack_s       = imem_ack & req_q;
  assign out_valid_s = hold_valid_q & ~br_taken;

  // Next-state logic for the fetch FSM, PC, request and held instruction.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    pc_out_d     = pc_out_q;
    ir_d         = ir_q;
    req_d        = req_q;
    squash_d     = squash_q;
    hold_valid_d = hold_valid_q;

    case (state_q)
      FETCH: begin
        if (!req_q) begin
          // Issue a new request; a redirect in this cycle is taken directly.
          pc_d     = br_taken ? br_target : pc_q;
          addr_d   = br_taken ? br_target : pc_q;
          req_d    = 1'b1;
          squash_d = 1'b0;
        end else if (ack_s) begin
          req_d = 1'b0;
          if (squash_q || br_taken) begin
            squash_d = 1'b0;
            pc_d     = br_taken ? br_target : pc_q;
          end else begin
            ir_d         = imem_rdata;
            pc_out_d     = pc_q;
            pc_d         = pc_q + PC_ONE;
            hold_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (br_taken) begin
          // Address must stay put until ack; the returning data is dropped.
          pc_d     = br_target;
          squash_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      HOLD: begin
        if (br_taken) begin
          hold_valid_d = 1'b0;
          pc_d         = br_target;
          addr_d       = br_target;
          req_d        = 1'b1;
          state_d      = FETCH;
        end else if (out_valid_s && out_ready) begin
          hold_valid_d = 1'b0;
          addr_d       = pc_q;
          req_d        = 1'b1;
          state_d      = FETCH;
        end else begin
          req_d = 1'b0;
        end
      end
      default: begin
        state_d      = FETCH;
        req_d        = 1'b0;
        squash_d     = 1'b0;
        hold_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      pc_out_q     <= {ADDR_W{1'b0}};
      ir_q         <= {INSTR_W{1'b0}};
      req_q        <= 1'b0;
      squash_q     <= 1'b0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      pc_out_q     <= pc_out_d;
      ir_q         <= ir_d;
      req_q        <= req_d;
      squash_q     <= squash_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = out_valid_s;
  assign pc_out    = pc_out_q;

  instr_field_split u_split (
    .instr  (ir_q),
    .opcode (opcode),
    .aluop  (aluop),
    .rd     (rd),
    .rn     (rn),
    .rm     (rm),
    .imm    (imm)
  );

endmodule
